mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter and address decoder for the shared data-memory/peripheral bus. It sits between the CPU MEM-stage data port (master 0) and a second master such as a loader or DMA engine (master 1). It serialises their accesses onto the single address/wdata bus and steers each access to DataMemory or PeripheralControl via the read/write strobes. It returns read data with a registered valid pulse and flags misaligned accesses.

## Interface
- ADDR_W, 32, address width (matches memory address bus)
- DATA_W, 32, data width (matches memory data bus)
- PERI_BASE, 32'h4000_0000, addresses >= PERI_BASE go to peripherals; below go to RAM
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- m0_req_i / m1_req_i  in  1  access request; held with addr/we/wdata stable until gnt
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  in  ADDR_W  byte address
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m0_gnt_o / m1_gnt_o  out  1  one-cycle pulse: request accepted
- m0_rvalid_o / m1_rvalid_o  out  1  one-cycle pulse: access complete, rdata/err valid
- m0_rdata_o / m1_rdata_o  out  DATA_W  read data (0 for writes and errors)
- m0_err_o / m1_err_o  out  1  misaligned access, qualified by rvalid
- m0_stall_o  out  1  req & ~(gnt) for master 0; feeds pipeline stall
- ram_cre_o, ram_cwe_o, peri_cre_o, peri_cwe_o  out  1  target strobes
- bus_addr_o  out  ADDR_W  shared address
- bus_wdata_o  out  DATA_W  shared write data
- ram_rdata_i, peri_rdata_i  in  DATA_W  combinational read data from targets

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req, latch winner, addr, we and wdata, then go to ACCESS. Otherwise stay.
- Arbitration is round-robin via a 1-bit priority pointer.
  - Reset value of the pointer is master 0.
  - When both masters request, the pointer's master wins.
  - After every grant, the pointer moves to the other master.
- ACCESS:
  - Assert gnt of the winner.
  - Drive bus_addr_o/bus_wdata_o from the latched registers.
  - Assert exactly one strobe, chosen by decode and we.
  - Capture the selected target rdata at the clock edge.
  - Go to DONE.
- Decode: addr >= PERI_BASE selects peri; otherwise ram.
- Misaligned access (addr[1:0] != 0): no strobe is asserted; err = 1 and rdata = 0 at DONE.
- DONE: assert rvalid, rdata and err for the winner.
  - If any req is pending, arbitrate and go straight to ACCESS.
  - Otherwise go to IDLE.
- rdata is 0 for writes. rdata/err hold their value until the next rvalid for that master.

## Timing
- All outputs are registered or decoded from state.
- Reset values:
  - State is IDLE, pointer is master 0.
  - gnt, rvalid, err, rdata, strobes, bus_addr and bus_wdata are all 0.
- Reset is asynchronous and may assert mid-transaction. Any in-flight access is dropped with no rvalid, and all strobes drop immediately.
- Latency: req first seen high at edge N gives gnt in cycle N+1 and rvalid in cycle N+2.
- Throughput: one access per 2 cycles when requests are back-to-back (ACCESS/DONE alternate, IDLE skipped).
- A master must keep req high until gnt. Dropping req earlier is a protocol violation; the latched access still completes.
- Reads are combinational from the targets. The bus is held stable for the full ACCESS cycle. Writes commit at the edge ending ACCESS.
- m0_stall_o is high from req assertion until the cycle of m0_gnt_o, inclusive of IDLE/DONE waiting cycles.

## Structure
- Shared package mem_bus_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - PERI_BASE default
  - ADDR_W/DATA_W defaults
  - master index constants M0/M1
- One sub-module: mem_rr_arb2, the 2-way round-robin pick plus pointer register. The FSM, latch, decode and response registers stay in mem_bus_arbiter.

## Test plan
- m0 read of 0x0000_0010 with RAM word 0xDEAD_BEEF -> ram_cre_o high in ACCESS only; m0_rvalid_o 2 cycles after req with rdata 0xDEAD_BEEF and err 0.
- m1 write of 0x1234_5678 to 0x4000_0004 -> peri_cwe_o for one cycle with that addr/wdata; m1_rvalid_o with rdata 0; no ram strobe.
- Both masters request continuously from reset -> grants alternate m0, m1, m0, m1, one per 2 cycles; m0_stall_o high during m1 accesses.
- m0 read of 0x0000_0002 -> no strobe; m0_rvalid_o with err 1 and rdata 0.
- rst pulled low during ACCESS -> strobes and gnt drop asynchronously; no rvalid; after release, the first request of both pending is granted to m0.
- Single request arriving in DONE of a previous access -> goes ACCESS directly; gnt follows rvalid with no IDLE cycle.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-master memory/peripheral bus arbiter.
package mem_bus_pkg;

   localparam int          ADDR_W_DEF    = 32;
   localparam int          DATA_W_DEF    = 32;
   localparam logic [31:0] PERI_BASE_DEF = 32'h4000_0000;

   // Master indices as carried by the 1-bit winner and priority pointer.
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin pick with its 1-bit priority pointer.
module mem_rr_arb2
   import mem_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       pick
);

   logic ptr_q;

   // A contested cycle goes to the pointer's master; otherwise the lone requester wins.
   always_comb begin
      pick = M0;
      if (req == 2'b11) begin
         pick = ptr_q;
      end else if (req[1]) begin
         pick = M1;
      end
   end

   // After each grant the master that did not win gets priority next time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= M0;
      end else if (advance) begin
         ptr_q <= ~pick;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and address decoder for the shared RAM/peripheral bus.
// Handshake: a master raises req with we/addr/wdata and holds them stable until
// it sees its one-cycle gnt pulse; the access completes with a one-cycle rvalid
// pulse on the following cycle, with rdata/err qualified by rvalid and held
// until that master's next rvalid. A req still high after gnt is a new request.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                DATA_W    = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] PERI_BASE = ADDR_W'(PERI_BASE_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m0_gnt_o,
   output logic              m1_gnt_o,
   output logic              m0_rvalid_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m0_err_o,
   output logic              m1_err_o,
   output logic              m0_stall_o,
   output logic              ram_cre_o,
   output logic              ram_cwe_o,
   output logic              peri_cre_o,
   output logic              peri_cwe_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   input  logic [DATA_W-1:0] peri_rdata_i,
   output state_t            dbg_state_o
);

   state_t            state_q, state_d;
   logic              win_q, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        req;
   logic              any_req, arb_en, pick;
   logic              misaligned, is_peri;
   logic [DATA_W-1:0] resp_rdata;

   assign req        = {m1_req_i, m0_req_i};
   assign any_req    = |req;
   // New accesses are only taken from IDLE or DONE, which skips IDLE under back-to-back load.
   assign arb_en     = ((state_q == IDLE) || (state_q == DONE)) && any_req;
   assign misaligned = |addr_q[1:0];
   assign is_peri    = (addr_q >= PERI_BASE);
   assign resp_rdata = (we_q || misaligned) ? '0 : (is_peri ? peri_rdata_i : ram_rdata_i);

   assign bus_addr_o  = addr_q;
   assign bus_wdata_o = wdata_q;
   assign dbg_state_o = state_q;
   assign m0_stall_o  = m0_req_i & ~m0_gnt_o;

   mem_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (arb_en),
      .pick    (pick)
   );

   // State register; reset drops any in-flight access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: ACCESS always completes through DONE; DONE chains straight into a pending request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = any_req ? ACCESS : IDLE;
         ACCESS:  state_d = DONE;
         DONE:    state_d = any_req ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the winning master's access so the bus stays stable through ACCESS.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q   <= M0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (arb_en) begin
         win_q   <= pick;
         we_q    <= pick ? m1_we_i    : m0_we_i;
         addr_q  <= pick ? m1_addr_i  : m0_addr_i;
         wdata_q <= pick ? m1_wdata_i : m0_wdata_i;
      end
   end

   // Grant, target strobes and rvalid are decoded from state and the latched access.
   always_comb begin
      m0_gnt_o    = 1'b0;
      m1_gnt_o    = 1'b0;
      m0_rvalid_o = 1'b0;
      m1_rvalid_o = 1'b0;
      ram_cre_o   = 1'b0;
      ram_cwe_o   = 1'b0;
      peri_cre_o  = 1'b0;
      peri_cwe_o  = 1'b0;
      case (state_q)
         ACCESS: begin
            if (win_q == M0) m0_gnt_o = 1'b1;
            else             m1_gnt_o = 1'b1;
            if (!misaligned) begin
               if (is_peri) begin
                  peri_cre_o = ~we_q;
                  peri_cwe_o = we_q;
               end else begin
                  ram_cre_o = ~we_q;
                  ram_cwe_o = we_q;
               end
            end
         end
         DONE: begin
            if (win_q == M0) m0_rvalid_o = 1'b1;
            else             m1_rvalid_o = 1'b1;
         end
         default: ;
      endcase
   end

   // Capture the response at the edge ending ACCESS; it holds until that master's next access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_rdata_o <= '0;
         m1_rdata_o <= '0;
         m0_err_o   <= 1'b0;
         m1_err_o   <= 1'b0;
      end else if (state_q == ACCESS) begin
         if (win_q == M0) begin
            m0_rdata_o <= resp_rdata;
            m0_err_o   <= misaligned;
         end else begin
            m1_rdata_o <= resp_rdata;
            m1_err_o   <= misaligned;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus two random
// masters, with a per-master scoreboard and a cycle-level protocol monitor.
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam logic [31:0] PB = 32'h4000_0000;

   logic        clk, rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, m0_stall;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_cre, ram_cwe, peri_cre, peri_cwe;
   logic [31:0] bus_addr, bus_wdata, ram_rdata, peri_rdata;
   state_t      dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: pending bus access {we, addr, wdata} and expected response {err, rdata}.
   logic [64:0] pend_q0[$], pend_q1[$];
   logic [32:0] exp_q0[$], exp_q1[$];

   mem_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
      .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
      .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
      .m0_err_o(m0_err), .m1_err_o(m1_err), .m0_stall_o(m0_stall),
      .ram_cre_o(ram_cre), .ram_cwe_o(ram_cwe), .peri_cre_o(peri_cre), .peri_cwe_o(peri_cwe),
      .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
      .ram_rdata_i(ram_rdata), .peri_rdata_i(peri_rdata),
      .dbg_state_o(dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Target models: read data is a fixed function of the address.
   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B9) ^ 32'h1357_2468);
   endfunction

   function automatic logic [31:0] peri_word(input logic [31:0] a);
      return ~a ^ 32'hA5A5_5A5A;
   endfunction

   assign ram_rdata  = ram_word(bus_addr);
   assign peri_rdata = peri_word(bus_addr);

   // Reference rules: misaligned -> err, rdata 0; writes -> rdata 0; reads from decoded target.
   function automatic logic [32:0] exp_resp(input logic we, input logic [31:0] a);
      if (a[1:0] != 2'b00) return {1'b1, 32'h0};
      if (we) return 33'h0;
      return {1'b0, (a >= PB) ? peri_word(a) : ram_word(a)};
   endfunction

   // Expected {ram_cre, ram_cwe, peri_cre, peri_cwe} during the access cycle.
   function automatic logic [3:0] exp_strb(input logic we, input logic [31:0] a);
      logic p;
      if (a[1:0] != 2'b00) return 4'b0000;
      p = (a >= PB);
      return {~p & ~we, ~p & we, p & ~we, p & we};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver: queue the expectation, raise req, hold until gnt (bounded), then drop req.
   // Called and returns at posedge+1.
   task automatic issue(input int m, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, output int lat);
      logic g;
      if (m == 0) begin
         pend_q0.push_back({we, a, wd});
         exp_q0.push_back(exp_resp(we, a));
         m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
      end else begin
         pend_q1.push_back({we, a, wd});
         exp_q1.push_back(exp_resp(we, a));
         m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
      end
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         g = (m == 0) ? m0_gnt : m1_gnt;
      end while (!g && lat < 40);
      chk((m == 0) ? "m0_gnt_seen" : "m1_gnt_seen", 64'(g), 64'(1));
      if (m == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
   endtask

   task automatic rand_driver(input int m, input int n);
      int lat;
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         logic        we;
         a = $urandom();
         case ($urandom_range(0, 4))
            0:       a = a & 32'h0000_0FFC;
            1:       a = PB | (a & 32'h0000_0FFC);
            2:       a[1:0] = 2'($urandom_range(1, 3));
            3:       a = PB - 32'd4;
            default: a = PB;
         endcase
         we = 1'($urandom_range(0, 1));
         issue(m, we, a, $urandom(), lat);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   // Monitor: spec-level model of grant timing/priority, bus contents and responses.
   logic [1:0] prev_g, prev_r;
   logic       mptr;
   always @(negedge clk) begin
      logic [1:0]  g, v, r, eg;
      logic        w;
      logic [64:0] p;
      logic [32:0] e;
      if (!rst) begin
         prev_g = 2'b00;
         prev_r = 2'b00;
         mptr   = 1'b0;
      end else begin
         g  = {m1_gnt, m0_gnt};
         v  = {m1_rvalid, m0_rvalid};
         r  = {m1_req, m0_req};
         eg = 2'b00;
         // An access is accepted whenever the previous cycle was not an access cycle and someone asked.
         if (prev_g == 2'b00 && prev_r != 2'b00) begin
            w    = (prev_r == 2'b11) ? mptr : prev_r[1];
            eg   = w ? 2'b10 : 2'b01;
            mptr = ~w;
         end
         chk("gnt_seq", 64'(g), 64'(eg));
         chk("rvalid_seq", 64'(v), 64'(prev_g));
         if (g == 2'b01 || g == 2'b10) begin
            if ((g[0] && pend_q0.size() == 0) || (g[1] && pend_q1.size() == 0)) begin
               n_checks++;
               n_fail++;
               $display("FAIL gnt_unexpected: got gnt %b with no queued request", g);
            end else begin
               if (g[0]) p = pend_q0.pop_front();
               else      p = pend_q1.pop_front();
               chk("bus_addr", 64'(bus_addr), 64'(p[63:32]));
               chk("bus_wdata", 64'(bus_wdata), 64'(p[31:0]));
               chk("strobes", 64'({ram_cre, ram_cwe, peri_cre, peri_cwe}), 64'(exp_strb(p[64], p[63:32])));
            end
         end else begin
            chk("strobes_idle", 64'({ram_cre, ram_cwe, peri_cre, peri_cwe}), 64'(0));
         end
         if (v[0]) begin
            if (exp_q0.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL m0_resp: got rvalid with empty expected queue");
            end else begin
               e = exp_q0.pop_front();
               chk("m0_resp", 64'({m0_err, m0_rdata}), 64'(e));
            end
         end
         if (v[1]) begin
            if (exp_q1.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL m1_resp: got rvalid with empty expected queue");
            end else begin
               e = exp_q1.pop_front();
               chk("m1_resp", 64'({m1_err, m1_rdata}), 64'(e));
            end
         end
         prev_g = g;
         prev_r = r;
      end
   end

   int lat0, lat1;
   logic [1:0] exp_g;

   initial begin
      // Reset block
      rst = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt_rvalid", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 64'(0));
      chk("rst_rdata_err", 64'({m0_err, m1_err, m0_rdata, m1_rdata}), 64'(0));
      chk("rst_strobes", 64'({ram_cre, ram_cwe, peri_cre, peri_cwe}), 64'(0));
      chk("rst_bus", 64'({bus_addr, bus_wdata}), 64'(0));
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      rst = 1'b1;
      @(posedge clk); #1;

      // Both masters request continuously: m0, m1, m0, m1, one grant every 2 cycles.
      pend_q0.push_back({1'b0, 32'h0000_0100, 32'h0});
      pend_q0.push_back({1'b0, 32'h0000_0100, 32'h0});
      exp_q0.push_back(exp_resp(1'b0, 32'h0000_0100));
      exp_q0.push_back(exp_resp(1'b0, 32'h0000_0100));
      pend_q1.push_back({1'b1, 32'h4000_0008, 32'hCAFE_F00D});
      pend_q1.push_back({1'b1, 32'h4000_0008, 32'hCAFE_F00D});
      exp_q1.push_back(exp_resp(1'b1, 32'h4000_0008));
      exp_q1.push_back(exp_resp(1'b1, 32'h4000_0008));
      m0_we = 1'b0; m0_addr = 32'h0000_0100; m0_wdata = 32'h0;
      m1_we = 1'b1; m1_addr = 32'h4000_0008; m1_wdata = 32'hCAFE_F00D;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         case (c)
            1, 5:    exp_g = 2'b01;
            3, 7:    exp_g = 2'b10;
            default: exp_g = 2'b00;
         endcase
         chk("alt_gnt", 64'({m1_gnt, m0_gnt}), 64'(exp_g));
         if (c == 1) chk("stall_on_gnt", 64'(m0_stall), 64'(0));
         if (c == 3) chk("stall_m1_access", 64'(m0_stall), 64'(1));
         if (c == 5) m0_req = 1'b0;
         if (c == 7) m1_req = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;

      // m0 read of RAM word 0x10.
      issue(0, 1'b0, 32'h0000_0010, 32'h0, lat0);
      chk("rd_gnt_lat", 64'(lat0), 64'(1));
      chk("rd_ram_cre", 64'({ram_cre, ram_cwe, peri_cre, peri_cwe}), 64'(4'b1000));
      @(posedge clk); #1;
      chk("rd_rvalid", 64'(m0_rvalid), 64'(1));
      chk("rd_data", 64'({m0_err, m0_rdata}), 64'({1'b0, 32'hDEAD_BEEF}));
      @(posedge clk); #1;

      // m1 write to a peripheral.
      issue(1, 1'b1, 32'h4000_0004, 32'h1234_5678, lat1);
      chk("wr_gnt_lat", 64'(lat1), 64'(1));
      chk("wr_peri_cwe", 64'({ram_cre, ram_cwe, peri_cre, peri_cwe}), 64'(4'b0001));
      chk("wr_bus", 64'({bus_addr, bus_wdata}), 64'({32'h4000_0004, 32'h1234_5678}));
      @(posedge clk); #1;
      chk("wr_rvalid", 64'({m1_rvalid, m1_rdata}), 64'({1'b1, 32'h0}));
      @(posedge clk); #1;

      // m0 misaligned read.
      issue(0, 1'b0, 32'h0000_0002, 32'h0, lat0);
      chk("mis_no_strobe", 64'({ram_cre, ram_cwe, peri_cre, peri_cwe}), 64'(0));
      @(posedge clk); #1;
      chk("mis_resp", 64'({m0_rvalid, m0_err, m0_rdata}), 64'({1'b1, 1'b1, 32'h0}));
      @(posedge clk); #1;

      // m1 request arriving in DONE of an m0 access goes straight to ACCESS.
      fork
         issue(0, 1'b0, 32'h0000_0040, 32'h0, lat0);
         begin
            int k;
            k = 0;
            do begin
               @(posedge clk); #1;
               k++;
            end while (!m0_gnt && k < 20);
            @(posedge clk); #1;
            chk("done_rvalid", 64'(m0_rvalid), 64'(1));
            issue(1, 1'b1, 32'h4000_0010, 32'h0BAD_F00D, lat1);
            chk("done_chain_lat", 64'(lat1), 64'(1));
         end
      join
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Reset asserted during ACCESS drops the access.
      pend_q0.push_back({1'b0, 32'h0000_0020, 32'h0});
      m0_we = 1'b0; m0_addr = 32'h0000_0020; m0_wdata = 32'h0; m0_req = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_gnt", 64'({m0_gnt, ram_cre}), 64'(2'b11));
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("rst_mid_drop", 64'({m0_gnt, m1_gnt, ram_cre, ram_cwe, peri_cre, peri_cwe}), 64'(0));
      chk("rst_mid_state", 64'(dbg_state), 64'(IDLE));
      m0_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_rdata", 64'({m0_rvalid, m0_rdata}), 64'(0));
      fork
         issue(0, 1'b0, 32'h0000_0030, 32'h0, lat0);
         issue(1, 1'b0, 32'h4000_0030, 32'h0, lat1);
      join
      chk("post_rst_m0_first", 64'(lat0), 64'(1));
      chk("post_rst_m1_second", 64'(lat1), 64'(3));

      // Random traffic from both masters.
      fork
         rand_driver(0, 25);
         rand_driver(1, 25);
      join

      // Drain, bounded.
      for (int k = 0; k < 10 && (exp_q0.size() + exp_q1.size() + pend_q0.size() + pend_q1.size()) != 0; k++) begin
         @(posedge clk); #1;
      end
      chk("drain_exp_q0", 64'(exp_q0.size()), 64'(0));
      chk("drain_exp_q1", 64'(exp_q1.size()), 64'(0));
      chk("drain_pend", 64'(pend_q0.size() + pend_q1.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
